// File: rtl/writeback_pkg.sv
// Shared pipeline constants: writeback result sources and load funct3 codes.
// Decode and memory stages import these same encodings.
package writeback_pkg;

    typedef enum logic [1:0] {
        WbSrcAlu = 2'd0,
        WbSrcMem = 2'd1,
        WbSrcPc4 = 2'd2,
        WbSrcCsr = 2'd3
    } wb_src_e;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;

endpackage

// File: rtl/load_ext.sv
// Load data extraction: picks byte/halfword from a raw memory word and extends it.
module load_ext
    import writeback_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned halfwords simply use addr[1]; no trap is raised here.
    assign byte_sel = word[8*addr +: 8];
    assign half_sel = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = word;
        case (funct3)
            Funct3Lb:  result = {{24{byte_sel[7]}}, byte_sel};
            Funct3Lbu: result = {24'd0, byte_sel};
            Funct3Lh:  result = {{16{half_sel[15]}}, half_sel};
            Funct3Lhu: result = {16'd0, half_sel};
            Funct3Lw:  result = word;
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Writeback stage: M->W pipeline register, result select, x0 suppression, instret.
module writeback
    import writeback_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid_m,
    input  logic            rd_write_m,
    input  logic [1:0]      rd_write_src_m,
    input  logic [4:0]      rd_m,
    input  logic [XLEN-1:0] pc_m,
    input  logic [XLEN-1:0] alu_res_m,
    input  logic [2:0]      load_funct3_m,
    input  logic [XLEN-1:0] mem_read_data_m,
    input  logic [XLEN-1:0] csr_data_m,
    input  logic            mem_valid_m,
    input  logic            stall_w,
    output logic            rd_write_w,
    output logic [4:0]      rd_w,
    output logic [XLEN-1:0] rd_data_w,
    output logic            mem_wait_w,
    output logic [63:0]     instret_w
);

    logic            valid_q,    valid_d;
    logic            rd_write_q, rd_write_d;
    logic [4:0]      rd_q,       rd_d;
    wb_src_e         src_q,      src_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] alu_res_q,  alu_res_d;
    logic [2:0]      funct3_q,   funct3_d;
    logic [XLEN-1:0] mem_data_q, mem_data_d;
    logic [XLEN-1:0] csr_data_q, csr_data_d;
    logic [63:0]     instret_q,  instret_d;
    logic [XLEN-1:0] load_data;

    assign mem_wait_w = instr_valid_m && (rd_write_src_m == WbSrcMem) && !mem_valid_m;

    // Stall beats wait: a stalled W register holds rather than taking a bubble.
    always_comb begin
        valid_d    = valid_q;
        rd_write_d = rd_write_q;
        rd_d       = rd_q;
        src_d      = src_q;
        pc_d       = pc_q;
        alu_res_d  = alu_res_q;
        funct3_d   = funct3_q;
        mem_data_d = mem_data_q;
        csr_data_d = csr_data_q;
        instret_d  = instret_q;
        if (!stall_w) begin
            if (valid_q) begin
                instret_d = instret_q + 64'd1;
            end
            if (mem_wait_w) begin
                valid_d    = 1'b0;
                rd_write_d = 1'b0;
            end else begin
                valid_d    = instr_valid_m;
                rd_write_d = rd_write_m;
                rd_d       = rd_m;
                src_d      = wb_src_e'(rd_write_src_m);
                pc_d       = pc_m;
                alu_res_d  = alu_res_m;
                funct3_d   = load_funct3_m;
                mem_data_d = mem_read_data_m;
                csr_data_d = csr_data_m;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rd_write_q <= 1'b0;
            rd_q       <= 5'd0;
            src_q      <= WbSrcAlu;
            pc_q       <= '0;
            alu_res_q  <= '0;
            funct3_q   <= 3'd0;
            mem_data_q <= '0;
            csr_data_q <= '0;
            instret_q  <= 64'd0;
        end else begin
            valid_q    <= valid_d;
            rd_write_q <= rd_write_d;
            rd_q       <= rd_d;
            src_q      <= src_d;
            pc_q       <= pc_d;
            alu_res_q  <= alu_res_d;
            funct3_q   <= funct3_d;
            mem_data_q <= mem_data_d;
            csr_data_q <= csr_data_d;
            instret_q  <= instret_d;
        end
    end

    load_ext u_load_ext (
        .funct3 (funct3_q),
        .addr   (alu_res_q[1:0]),
        .word   (mem_data_q),
        .result (load_data)
    );

    always_comb begin
        rd_data_w = alu_res_q;
        unique case (src_q)
            WbSrcAlu: rd_data_w = alu_res_q;
            WbSrcMem: rd_data_w = load_data;
            WbSrcPc4: rd_data_w = pc_q + XLEN'(4);
            WbSrcCsr: rd_data_w = csr_data_q;
            default:  rd_data_w = alu_res_q;
        endcase
    end

    assign rd_write_w = valid_q && rd_write_q && (rd_q != 5'd0);
    assign rd_w       = rd_q;
    assign instret_w  = instret_q;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios plus randomized traffic
// against a result-level reference model.
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid_m, rd_write_m, mem_valid_m, stall_w;
    logic [1:0]  rd_write_src_m;
    logic [4:0]  rd_m;
    logic [31:0] pc_m, alu_res_m, mem_read_data_m, csr_data_m;
    logic [2:0]  load_funct3_m;
    logic        rd_write_w, mem_wait_w;
    logic [4:0]  rd_w;
    logic [31:0] rd_data_w;
    logic [63:0] instret_w;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the W stage should present, computed at capture time.
    bit          m_valid, m_wr;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [63:0] m_instret;

    writeback #(.XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_valid_m   (instr_valid_m),
        .rd_write_m      (rd_write_m),
        .rd_write_src_m  (rd_write_src_m),
        .rd_m            (rd_m),
        .pc_m            (pc_m),
        .alu_res_m       (alu_res_m),
        .load_funct3_m   (load_funct3_m),
        .mem_read_data_m (mem_read_data_m),
        .csr_data_m      (csr_data_m),
        .mem_valid_m     (mem_valid_m),
        .stall_w         (stall_w),
        .rd_write_w      (rd_write_w),
        .rd_w            (rd_w),
        .rd_data_w       (rd_data_w),
        .mem_wait_w      (mem_wait_w),
        .instret_w       (instret_w)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (a * 8)) & 32'hFF;
        h = (w >> (a[1] * 16)) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] src, input logic [31:0] pc,
                                               input logic [31:0] alu, input logic [2:0] f3,
                                               input logic [31:0] word, input logic [31:0] csr);
        case (src)
            2'd0:    return alu;
            2'd1:    return ref_load(f3, alu[1:0], word);
            2'd2:    return pc + 32'd4;
            default: return csr;
        endcase
    endfunction

    task automatic model_reset();
        m_valid   = 0;
        m_wr      = 0;
        m_rd      = 5'd0;
        m_data    = 32'd0;
        m_instret = 64'd0;
    endtask

    task automatic drive(input bit iv, input bit wr, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [2:0] f3,
                         input logic [31:0] word, input logic [31:0] csr, input bit mv,
                         input bit st);
        instr_valid_m   = iv;
        rd_write_m      = wr;
        rd_write_src_m  = src;
        rd_m            = rd;
        pc_m            = pc;
        alu_res_m       = alu;
        load_funct3_m   = f3;
        mem_read_data_m = word;
        csr_data_m      = csr;
        mem_valid_m     = mv;
        stall_w         = st;
    endtask

    // One clock: drive M inputs, check the wait flag, clock, then check W outputs.
    task automatic step(input bit iv, input bit wr, input logic [1:0] src, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] alu, input logic [2:0] f3,
                        input logic [31:0] word, input logic [31:0] csr, input bit mv,
                        input bit st, input string tag);
        bit exp_wait;
        drive(iv, wr, src, rd, pc, alu, f3, word, csr, mv, st);
        exp_wait = iv && (src == 2'd1) && !mv;
        @(negedge clk);
        check_val({tag, ".mem_wait"}, {63'd0, mem_wait_w}, {63'd0, exp_wait});
        @(posedge clk);
        if (!st) begin
            if (m_valid) m_instret = m_instret + 64'd1;
            if (exp_wait) begin
                m_valid = 0;
                m_wr    = 0;
            end else begin
                m_valid = iv;
                m_wr    = wr;
                m_rd    = rd;
                m_data  = ref_result(src, pc, alu, f3, word, csr);
            end
        end
        #1;
        check_val({tag, ".rd_write"}, {63'd0, rd_write_w},
                  {63'd0, (m_valid && m_wr && (m_rd != 5'd0))});
        if (m_valid) begin
            check_val({tag, ".rd"}, {59'd0, rd_w}, {59'd0, m_rd});
            check_val({tag, ".rd_data"}, {32'd0, rd_data_w}, {32'd0, m_data});
        end
        check_val({tag, ".instret"}, instret_w, m_instret);
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] v, input string tag);
        step(1, 1, 2'd0, rd, 32'h200, v, 3'd2, 32'h0, 32'h0, 1, 0, tag);
    endtask

    initial begin
        logic [63:0] inst_before;
        model_reset();
        rst_n = 1'b0;
        drive(0, 0, 2'd0, 5'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("reset.rd_write", {63'd0, rd_write_w}, 64'd0);
        check_val("reset.rd_data", {32'd0, rd_data_w}, 64'd0);
        check_val("reset.instret", instret_w, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU result with one-cycle latency, then retirement bumps instret.
        alu_op(5'd5, 32'h1234, "alu");
        check_val("alu.const_data", {32'd0, rd_data_w}, 64'h1234);
        alu_op(5'd9, 32'h55, "alu2");
        check_val("alu.instret_plus1", instret_w, 64'd1);

        // Load extension cases.
        step(1, 1, 2'd1, 5'd6, 32'h300, 32'h1003, 3'b000, 32'h80FF_FF7F, 0, 1, 0, "lb");
        check_val("lb.const", {32'd0, rd_data_w}, 64'hFFFF_FF80);
        step(1, 1, 2'd1, 5'd6, 32'h304, 32'h1003, 3'b100, 32'h80FF_FF7F, 0, 1, 0, "lbu");
        check_val("lbu.const", {32'd0, rd_data_w}, 64'h0000_0080);
        step(1, 1, 2'd1, 5'd6, 32'h308, 32'h1000, 3'b001, 32'h0000_8001, 0, 1, 0, "lh");
        check_val("lh.const", {32'd0, rd_data_w}, 64'hFFFF_8001);

        // Load waiting three cycles for memory: bubbles, then data.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 2'd1, 5'd7, 32'h30C, 32'h2000, 3'b010, 32'hDEAD_BEEF, 0, 0, 0, "wait");
            check_val("wait.bubble", {63'd0, rd_write_w}, 64'd0);
        end
        inst_before = instret_w;
        step(1, 1, 2'd1, 5'd7, 32'h30C, 32'h2000, 3'b010, 32'hCAFE_F00D, 0, 1, 0, "wait_done");
        check_val("wait_done.instret_const", instret_w, inst_before);
        check_val("wait_done.const", {32'd0, rd_data_w}, 64'hCAFE_F00D);

        // JAL link value, pc+4 wrap, and x0 suppression.
        step(1, 1, 2'd2, 5'd1, 32'h100, 32'h0, 3'd0, 32'h0, 0, 1, 0, "jal");
        check_val("jal.const", {32'd0, rd_data_w}, 64'h104);
        step(1, 1, 2'd2, 5'd2, 32'hFFFF_FFFC, 32'h0, 3'd0, 32'h0, 0, 1, 0, "pc4wrap");
        check_val("pc4wrap.const", {32'd0, rd_data_w}, 64'h0);
        alu_op(5'd0, 32'h77, "x0");
        check_val("x0.no_write", {63'd0, rd_write_w}, 64'd0);
        inst_before = instret_w;
        alu_op(5'd3, 32'h88, "after_x0");
        check_val("x0.instret_plus1", instret_w, inst_before + 64'd1);
        step(1, 1, 2'd3, 5'd4, 32'h0, 32'h0, 3'd0, 32'h0, 32'hC5C5_0001, 1, 0, "csr");

        // Two stall cycles freeze everything, including a stall during a memory wait.
        inst_before = instret_w;
        step(1, 1, 2'd0, 5'd11, 32'h0, 32'hAAAA, 3'd0, 32'h0, 0, 1, 1, "stall1");
        step(1, 1, 2'd1, 5'd12, 32'h0, 32'hBBBB, 3'd0, 32'h0, 0, 0, 1, "stall_wait");
        check_val("stall.frozen_data", {32'd0, rd_data_w}, 64'hC5C5_0001);
        check_val("stall.frozen_instret", instret_w, inst_before);
        check_val("stall_wait.no_bubble", {63'd0, rd_write_w}, 64'd1);

        // instret wrap: preload all-ones, then one retirement.
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        check_val("wrap.preload", instret_w, 64'hFFFF_FFFF_FFFF_FFFF);
        alu_op(5'd13, 32'h1, "wrap");
        check_val("wrap.zero", instret_w, 64'd0);
        alu_op(5'd14, 32'h2, "wrap2");

        // Asynchronous reset in the middle of a stalled wait.
        drive(1, 1, 2'd1, 5'd15, 32'h0, 32'h0, 3'd0, 32'h0, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_mid.rd_write", {63'd0, rd_write_w}, 64'd0);
        check_val("rst_mid.instret", instret_w, 64'd0);
        check_val("rst_mid.mem_wait", {63'd0, mem_wait_w}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 1, 2'd1, 5'd15, 32'h0, 32'h0, 3'd0, 32'h0, 0, 0, 0, "rst_after_wait");
        alu_op(5'd16, 32'h99, "rst_after");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 8) != 0, $urandom % 2 == 0 ? 1'b0 : 1'b1,
                 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                 3'($urandom_range(0, 7)), $urandom, $urandom,
                 ($urandom % 4) != 0, ($urandom % 5) == 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
